fetch_stage: RTL and testbench

//  - IF stage of the 5-stage RISC-V pipeline core. Owns the program counter and drives the

---
 rtl/riscv_pkg.sv | 8 +
 rtl/if_id_reg.sv | 63 ++++++
 rtl/fetch_stage.sv | 87 ++++++++
 tb/tb_fetch_stage.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared constants for the RV32 pipeline: data width, bubble encoding and
// default reset/IMEM parameters.
package riscv_pkg;
  localparam int unsigned XLEN            = 32;
  localparam logic [31:0] NOP_INSTR_C     = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_C      = 32'h0000_0000;
  localparam int unsigned IMEM_WORDS_C    = 1024;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register bundle with bubble (highest priority), hold and load.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_C
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_bubble,
  input  logic            i_hold,
  input  logic [XLEN-1:0] i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_pc_plus4,
  input  logic            i_misalign,
  input  logic            i_fault,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus4,
  output logic            o_valid,
  output logic            o_misalign,
  output logic            o_fault
);

  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc_plus4;
  logic            r_valid;
  logic            r_misalign;
  logic            r_fault;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr    <= NOP_INSTR;
      r_pc       <= '0;
      r_pc_plus4 <= '0;
      r_valid    <= 1'b0;
      r_misalign <= 1'b0;
      r_fault    <= 1'b0;
    end else if (i_bubble) begin
      r_instr    <= NOP_INSTR;
      r_pc       <= '0;
      r_pc_plus4 <= '0;
      r_valid    <= 1'b0;
      r_misalign <= 1'b0;
      r_fault    <= 1'b0;
    end else if (!i_hold) begin
      r_instr    <= i_instr;
      r_pc       <= i_pc;
      r_pc_plus4 <= i_pc_plus4;
      r_valid    <= 1'b1;
      r_misalign <= i_misalign;
      r_fault    <= i_fault;
    end
  end

  assign o_instr    = r_instr;
  assign o_pc       = r_pc;
  assign o_pc_plus4 = r_pc_plus4;
  assign o_valid    = r_valid;
  assign o_misalign = r_misalign;
  assign o_fault    = r_fault;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, next-PC selection, IMEM range check and IF/ID capture.
// The hazard unit stalls with stall_f and stall_d together; pc_src_e overrides both.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_C,
  parameter logic [XLEN-1:0] NOP_INSTR  = NOP_INSTR_C,
  parameter int unsigned     IMEM_WORDS = IMEM_WORDS_C
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_f,
  input  logic            stall_d,
  input  logic            flush_d,
  input  logic            pc_src_e,
  input  logic [XLEN-1:0] pc_target_e,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] pc_f,
  output logic [XLEN-1:0] instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d,
  output logic            valid_d,
  output logic            misalign_d,
  output logic            fault_d
);

  logic [XLEN-1:0] r_pc;
  logic            r_misalign_f;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_pc_next;
  logic            w_misalign_next;
  logic            w_fault;
  logic [XLEN-1:0] w_instr_f;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_fault    = {2'b00, r_pc[XLEN-1:2]} >= IMEM_WORDS;
  assign w_instr_f  = w_fault ? NOP_INSTR : imem_rdata;

  always_comb begin
    w_pc_next       = w_pc_plus4;
    w_misalign_next = 1'b0;
    if (pc_src_e) begin
      w_pc_next       = {pc_target_e[XLEN-1:2], 2'b00};
      w_misalign_next = |pc_target_e[1:0];
    end else if (stall_f) begin
      w_pc_next       = r_pc;
      w_misalign_next = r_misalign_f;
    end
  end

  // The misalign flag belongs to the fetch at the redirected PC, so it holds
  // while that fetch is stalled and clears once the PC moves on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_misalign_f <= 1'b0;
    end else begin
      r_pc         <= w_pc_next;
      r_misalign_f <= w_misalign_next;
    end
  end

  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .i_bubble   (flush_d | pc_src_e),
    .i_hold     (stall_d),
    .i_instr    (w_instr_f),
    .i_pc       (r_pc),
    .i_pc_plus4 (w_pc_plus4),
    .i_misalign (r_misalign_f),
    .i_fault    (w_fault),
    .o_instr    (instr_d),
    .o_pc       (pc_d),
    .o_pc_plus4 (pc_plus4_d),
    .o_valid    (valid_d),
    .o_misalign (misalign_d),
    .o_fault    (fault_d)
  );

  assign imem_addr = r_pc;
  assign pc_f      = r_pc;

  a_stall_pair: assert property (@(posedge clk) disable iff (rst) !(stall_f && !stall_d));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: hand-computed per-cycle expectations go into a
// queue at drive time and a monitor compares them after each rising edge.
module tb_fetch_stage;

  typedef struct packed {
    logic [31:0] pc_f;
    logic [31:0] instr;
    logic [31:0] pc_d;
    logic        valid;
    logic        mis;
    logic        flt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_f, stall_d, flush_d, pc_src_e;
  logic [31:0] pc_target_e;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] pc_f, instr_d, pc_d, pc_plus4_d;
  logic        valid_d, misalign_d, fault_d;

  logic [31:0] mem [0:1023];
  exp_t        exp_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .flush_d     (flush_d),
    .pc_src_e    (pc_src_e),
    .pc_target_e (pc_target_e),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .pc_f        (pc_f),
    .instr_d     (instr_d),
    .pc_d        (pc_d),
    .pc_plus4_d  (pc_plus4_d),
    .valid_d     (valid_d),
    .misalign_d  (misalign_d),
    .fault_d     (fault_d)
  );

  // clock / reset
  always #5 clk = ~clk;

  // IMEM model: out-of-range reads return garbage that must never reach instr_d
  always_comb begin
    imem_rdata = 32'hDEAD_BEEF;
    if (imem_addr[31:12] == 20'd0) imem_rdata = mem[imem_addr[11:2]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input exp_t e);
    chk("pc_f",       pc_f,                e.pc_f);
    chk("imem_addr",  imem_addr,           e.pc_f);
    chk("instr_d",    instr_d,             e.instr);
    chk("pc_d",       pc_d,                e.pc_d);
    chk("pc_plus4_d", pc_plus4_d,          e.valid ? e.pc_d + 32'd4 : 32'd0);
    chk("valid_d",    {31'd0, valid_d},    {31'd0, e.valid});
    chk("misalign_d", {31'd0, misalign_d}, {31'd0, e.mis});
    chk("fault_d",    {31'd0, fault_d},    {31'd0, e.flt});
  endtask

  // driver: apply one cycle of inputs at a falling edge, queue the expected state after the next rising edge
  task automatic step(input logic sf, input logic sd, input logic fl, input logic src,
                      input logic [31:0] tgt, input logic [31:0] e_pc, input logic [31:0] e_instr,
                      input logic [31:0] e_pcd, input logic e_v, input logic e_m, input logic e_f);
    exp_t e;
    stall_f = sf; stall_d = sd; flush_d = fl; pc_src_e = src; pc_target_e = tgt;
    e.pc_f = e_pc; e.instr = e_instr; e.pc_d = e_pcd; e.valid = e_v; e.mis = e_m; e.flt = e_f;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // monitor / scoreboard
  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) check_all(exp_q.pop_front());
  end

  localparam logic [31:0] NOP = 32'h0000_0013;

  initial begin
    exp_t rst_e;
    rst_e = '{pc_f: 32'd0, instr: NOP, pc_d: 32'd0, valid: 1'b0, mis: 1'b0, flt: 1'b0};
    for (int k = 0; k < 1024; k++) mem[k] = 32'hA000_0000 | k;
    mem[0] = 32'h0050_0293; mem[1] = 32'h0030_0313;
    mem[2] = 32'h0062_83B3; mem[3] = 32'h0000_2403;
    rst = 1'b1; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0; pc_src_e = 1'b0;
    pc_target_e = 32'h0;
    repeat (3) @(negedge clk);
    check_all(rst_e);
    rst = 1'b0;

    // straight-line fetch
    step(0,0,0,0, 32'h0, 32'h04, 32'h0050_0293, 32'h00, 1,0,0);
    step(0,0,0,0, 32'h0, 32'h08, 32'h0030_0313, 32'h04, 1,0,0);
    // stall both at pc_f=8
    step(1,1,0,0, 32'h0, 32'h08, 32'h0030_0313, 32'h04, 1,0,0);
    step(1,1,0,0, 32'h0, 32'h08, 32'h0030_0313, 32'h04, 1,0,0);
    step(1,1,0,0, 32'h0, 32'h08, 32'h0030_0313, 32'h04, 1,0,0);
    step(0,0,0,0, 32'h0, 32'h0C, 32'h0062_83B3, 32'h08, 1,0,0);
    step(0,0,0,0, 32'h0, 32'h10, 32'h0000_2403, 32'h0C, 1,0,0);
    // aligned redirect to 0x40
    step(0,0,0,1, 32'h40, 32'h40, NOP,          32'h00, 0,0,0);
    step(0,0,0,0, 32'h0,  32'h44, 32'hA000_0010, 32'h40, 1,0,0);
    step(0,0,0,0, 32'h0,  32'h48, 32'hA000_0011, 32'h44, 1,0,0);
    // misaligned redirect to 0x42
    step(0,0,0,1, 32'h42, 32'h40, NOP,          32'h00, 0,0,0);
    step(0,0,0,0, 32'h0,  32'h44, 32'hA000_0010, 32'h40, 1,1,0);
    step(0,0,0,0, 32'h0,  32'h48, 32'hA000_0011, 32'h44, 1,0,0);
    // last in-range word, then fault beyond IMEM
    step(0,0,0,1, 32'hFFC, 32'hFFC,  NOP,          32'h000, 0,0,0);
    step(0,0,0,0, 32'h0,   32'h1000, 32'hA000_03FF, 32'hFFC, 1,0,0);
    step(0,0,0,0, 32'h0,   32'h1004, NOP,          32'h1000, 1,0,1);
    step(0,0,0,0, 32'h0,   32'h1008, NOP,          32'h1004, 1,0,1);
    // redirect together with stalls: redirect wins
    step(1,1,0,1, 32'h8, 32'h08, NOP,          32'h00, 0,0,0);
    step(0,0,0,0, 32'h0, 32'h0C, 32'h0062_83B3, 32'h08, 1,0,0);
    // flush together with stall
    step(1,1,1,0, 32'h0, 32'h0C, NOP,          32'h00, 0,0,0);
    step(0,0,0,0, 32'h0, 32'h10, 32'h0000_2403, 32'h0C, 1,0,0);
    // top-of-space fetch faults and PC wraps to 0
    step(0,0,0,1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, NOP, 32'h0, 0,0,0);
    step(0,0,0,0, 32'h0, 32'h00, NOP,          32'hFFFF_FFFC, 1,0,1);
    step(0,0,0,0, 32'h0, 32'h04, 32'h0050_0293, 32'h00, 1,0,0);
    // misalign flag survives a stall of its fetch
    step(0,0,0,1, 32'h41, 32'h40, NOP,          32'h00, 0,0,0);
    step(1,1,0,0, 32'h0,  32'h40, NOP,          32'h00, 0,0,0);
    step(0,0,0,0, 32'h0,  32'h44, 32'hA000_0010, 32'h40, 1,1,0);

    // mid-stream asynchronous reset
    stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0; pc_src_e = 1'b0;
    #2 rst = 1'b1;
    #1 check_all(rst_e);
    @(negedge clk);
    rst = 1'b0;
    step(0,0,0,0, 32'h0, 32'h04, 32'h0050_0293, 32'h00, 1,0,0);
    step(0,0,0,0, 32'h0, 32'h08, 32'h0030_0313, 32'h04, 1,0,0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
